dispatch_ctrl: RTL and testbench

- Issue-stage controller between the instruction queue/decoder and the out-of-order back end (ROB, RS, SLB, register-file rename).
- Latches one decoded instruction and allocates a ROB tag for it.
- Waits until the ROB and the target station (SLB for load/store, RS otherwise) both have space, then emits one-cycle issue strobes.
- Pops the instruction queue and drops all in-flight state on a mispredict flush.

---
 rtl/dispatch_ctrl_pkg.sv | 21 ++
 rtl/dispatch_ctrl_rob_tag_alloc.sv | 58 +++++
 rtl/dispatch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dispatch_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the dispatch controller: FSM encoding and stall-counter helpers.
package dispatch_ctrl_pkg;

    localparam int TAG_W_DEF  = 4;
    localparam int OP_W_DEF   = 6;
    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 32;
    localparam int REG_W_DEF  = 5;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        DISP_IDLE = 1'b0,
        DISP_HOLD = 1'b1
    } disp_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == STALL_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dispatch_ctrl_rob_tag_alloc.sv
// ROB tag allocator: tail pointer and occupancy counter with issue/commit/flush rules.
module dispatch_ctrl_rob_tag_alloc #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             issue_i,
    input  logic             commit_i,
    input  logic             flush_i,
    output logic [TAG_W-1:0] tail_o,
    output logic [TAG_W:0]   count_o,
    output logic             full_o
);

    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             commit_ok;

    // A commit against an empty ROB is spurious and dropped.
    assign commit_ok = commit_i && (count_q != '0);

    always_comb begin
        tail_d  = tail_q;
        count_d = count_q;
        if (en_i) begin
            if (flush_i) begin
                // Tail stays put: the ROB head realigns to it.
                count_d = '0;
            end else begin
                if (issue_i) begin
                    tail_d = tail_q + TAG_W'(1);
                end
                if (issue_i && !commit_ok) begin
                    count_d = count_q + (TAG_W+1)'(1);
                end else if (!issue_i && commit_ok) begin
                    count_d = count_q - (TAG_W+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign tail_o  = tail_q;
    assign count_o = count_q;
    // Occupancy never exceeds 2^TAG_W, so the top bit alone marks full.
    assign full_o  = count_q[TAG_W];

endmodule

// File: rtl/dispatch_ctrl.sv
// Issue-stage controller: latches one decoded instruction, allocates a ROB tag and
// issues it to the RS or SLB once both the ROB and the target station have room.
//
// state     | meaning
// DISP_IDLE | no instruction held
// DISP_HOLD | instruction latched, waiting for ROB and station space
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int TAG_W  = TAG_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iq_empty,
    output logic              iq_pop,
    input  logic [PC_W-1:0]   dec_pc,
    input  logic [OP_W-1:0]   dec_op,
    input  logic [DATA_W-1:0] dec_imm,
    input  logic [REG_W-1:0]  dec_rd,
    input  logic [REG_W-1:0]  dec_rs1,
    input  logic [REG_W-1:0]  dec_rs2,
    input  logic              dec_is_sl,
    input  logic              rs_full,
    input  logic              slb_full,
    input  logic              commit,
    input  logic              flush,
    output logic              issue_rs,
    output logic              issue_slb,
    output logic              issue_rob,
    output logic [TAG_W-1:0]  issue_tag,
    output logic [PC_W-1:0]   issue_pc,
    output logic [OP_W-1:0]   issue_op,
    output logic [DATA_W-1:0] issue_imm,
    output logic [REG_W-1:0]  issue_rd,
    output logic [REG_W-1:0]  issue_rs1,
    output logic [REG_W-1:0]  issue_rs2,
    output logic [TAG_W:0]    rob_count,
    output logic [15:0]       stall_cnt
);

    disp_state_e       state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [REG_W-1:0]  rs1_q, rs1_d;
    logic [REG_W-1:0]  rs2_q, rs2_d;
    logic              sl_q, sl_d;
    logic [15:0]       stall_q, stall_d;

    logic              load;
    logic              ok;
    logic              rob_full;
    logic [TAG_W-1:0]  tail;

    assign ok = !rob_full && (sl_q ? !slb_full : !rs_full);

    // Strobes are Mealy; reset is folded in so an async reset silences them at once.
    always_comb begin
        state_d   = state_q;
        stall_d   = stall_q;
        load      = 1'b0;
        iq_pop    = 1'b0;
        issue_rob = 1'b0;
        issue_rs  = 1'b0;
        issue_slb = 1'b0;
        if (!rst && rdy) begin
            if (flush) begin
                state_d = DISP_IDLE;
            end else begin
                case (state_q)
                    DISP_IDLE: begin
                        if (!iq_empty) begin
                            iq_pop  = 1'b1;
                            load    = 1'b1;
                            state_d = DISP_HOLD;
                        end
                    end
                    DISP_HOLD: begin
                        if (ok) begin
                            issue_rob = 1'b1;
                            issue_rs  = !sl_q;
                            issue_slb = sl_q;
                            if (!iq_empty) begin
                                iq_pop = 1'b1;
                                load   = 1'b1;
                            end else begin
                                state_d = DISP_IDLE;
                            end
                        end else begin
                            stall_d = sat_inc16(stall_q);
                        end
                    end
                    default: state_d = DISP_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        pc_d  = pc_q;
        op_d  = op_q;
        imm_d = imm_q;
        rd_d  = rd_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        sl_d  = sl_q;
        if (load) begin
            pc_d  = dec_pc;
            op_d  = dec_op;
            imm_d = dec_imm;
            rd_d  = dec_rd;
            rs1_d = dec_rs1;
            rs2_d = dec_rs2;
            sl_d  = dec_is_sl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DISP_IDLE;
            pc_q    <= '0;
            op_q    <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            sl_q    <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            sl_q    <= sl_d;
            stall_q <= stall_d;
        end
    end

    dispatch_ctrl_rob_tag_alloc #(
        .TAG_W (TAG_W)
    ) u_tag_alloc (
        .clk      (clk),
        .rst      (rst),
        .en_i     (rdy),
        .issue_i  (issue_rob),
        .commit_i (commit),
        .flush_i  (flush),
        .tail_o   (tail),
        .count_o  (rob_count),
        .full_o   (rob_full)
    );

    assign issue_tag = tail;
    assign issue_pc  = pc_q;
    assign issue_op  = op_q;
    assign issue_imm = imm_q;
    assign issue_rd  = rd_q;
    assign issue_rs1 = rs1_q;
    assign issue_rs2 = rs2_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: table-driven cycle vectors plus a field scoreboard.
module tb_dispatch_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        iq_empty;
    logic        iq_pop;
    logic [31:0] dec_pc;
    logic [5:0]  dec_op;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic        dec_is_sl;
    logic        rs_full, slb_full, commit, flush;
    logic        issue_rs, issue_slb, issue_rob;
    logic [3:0]  issue_tag;
    logic [31:0] issue_pc;
    logic [5:0]  issue_op;
    logic [31:0] issue_imm;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic [4:0]  rob_count;
    logic [15:0] stall_cnt;

    dispatch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .iq_empty  (iq_empty),
        .iq_pop    (iq_pop),
        .dec_pc    (dec_pc),
        .dec_op    (dec_op),
        .dec_imm   (dec_imm),
        .dec_rd    (dec_rd),
        .dec_rs1   (dec_rs1),
        .dec_rs2   (dec_rs2),
        .dec_is_sl (dec_is_sl),
        .rs_full   (rs_full),
        .slb_full  (slb_full),
        .commit    (commit),
        .flush     (flush),
        .issue_rs  (issue_rs),
        .issue_slb (issue_slb),
        .issue_rob (issue_rob),
        .issue_tag (issue_tag),
        .issue_pc  (issue_pc),
        .issue_op  (issue_op),
        .issue_imm (issue_imm),
        .issue_rd  (issue_rd),
        .issue_rs1 (issue_rs1),
        .issue_rs2 (issue_rs2),
        .rob_count (rob_count),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rdy, empty, sl, rsf, slbf, cmt, fl;
        logic pop, rob, rs, slb;
        int   tag;
        int   cnt;
        int   stall;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic        sl;
    } instr_t;

    instr_t sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    vec_t   tbl[29];

    function automatic vec_t mk(input logic r, e, s, rf, sf, c, f,
                                input logic p, rb, rr, rl,
                                input int t, input int n, input int st);
        vec_t v;
        v.rdy = r;  v.empty = e; v.sl = s; v.rsf = rf; v.slbf = sf; v.cmt = c; v.fl = f;
        v.pop = p;  v.rob = rb;  v.rs = rr; v.slb = rl;
        v.tag = t;  v.cnt = n;   v.stall = st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the negedge, sample #1 later, then advance.
    task automatic step(input vec_t v, input string nm);
        instr_t e;
        rdy       = v.rdy;
        iq_empty  = v.empty;
        dec_is_sl = v.sl;
        rs_full   = v.rsf;
        slb_full  = v.slbf;
        commit    = v.cmt;
        flush     = v.fl;
        dec_pc    = $urandom;
        dec_op    = 6'($urandom);
        dec_imm   = $urandom;
        dec_rd    = 5'($urandom);
        dec_rs1   = 5'($urandom);
        dec_rs2   = 5'($urandom);
        #1;
        chk({nm, ".pop"}, iq_pop, v.pop);
        chk({nm, ".rob"}, issue_rob, v.rob);
        chk({nm, ".rs"}, issue_rs, v.rs);
        chk({nm, ".slb"}, issue_slb, v.slb);
        if (v.rob) chk({nm, ".tag"}, issue_tag, v.tag);
        if (v.cnt >= 0) chk({nm, ".cnt"}, rob_count, v.cnt);
        if (v.stall >= 0) chk({nm, ".stall"}, stall_cnt, v.stall);
        if (issue_rob) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s.sb: issue with no pending instruction", nm);
            end else begin
                e = sb.pop_front();
                chk({nm, ".pc"}, issue_pc, e.pc);
                chk({nm, ".op"}, issue_op, e.op);
                chk({nm, ".imm"}, issue_imm, e.imm);
                chk({nm, ".regs"}, {issue_rd, issue_rs1, issue_rs2}, {e.rd, e.rs1, e.rs2});
                chk({nm, ".route"}, {issue_slb, issue_rs}, {e.sl, !e.sl});
            end
        end
        if (rdy && flush) sb.delete();
        if (iq_pop) begin
            e.pc = dec_pc; e.op = dec_op; e.imm = dec_imm;
            e.rd = dec_rd; e.rs1 = dec_rs1; e.rs2 = dec_rs2; e.sl = dec_is_sl;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1; iq_empty = 1'b0; dec_is_sl = 1'b0;
        rs_full = 1'b0; slb_full = 1'b0; commit = 1'b0; flush = 1'b0;
        dec_pc = '0; dec_op = '0; dec_imm = '0; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        chk("rst.pop", iq_pop, 1'b0);
        chk("rst.strobes", {issue_rob, issue_rs, issue_slb}, 3'b000);
        chk("rst.cnt", rob_count, 5'd0);
        chk("rst.stall", stall_cnt, 16'd0);
        chk("rst.fields", {issue_pc, issue_op, issue_rd}, '0);
        iq_empty = 1'b1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;

        //            rdy e sl rsf slbf cmt fl | pop rob rs slb  tag cnt stall
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0,  0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0,  1, 1, 0);
        tbl[3]  = mk(1, 1, 0, 0, 0, 0, 0,  0, 1, 1, 0,  2, 2, 0);
        tbl[4]  = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 3, 0);
        tbl[5]  = mk(1, 0, 1, 0, 1, 0, 0,  1, 0, 0, 0,  0, 3, 0);
        tbl[6]  = mk(1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0,  0, 3, 0);
        tbl[7]  = mk(1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0,  0, 3, 1);
        tbl[8]  = mk(1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0,  0, 3, 2);
        tbl[9]  = mk(1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0,  0, 3, 3);
        tbl[10] = mk(1, 1, 1, 1, 0, 0, 0,  0, 1, 0, 1,  3, 3, 4);
        tbl[11] = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 4, 4);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 4, 4);
        tbl[13] = mk(1, 1, 0, 0, 0, 0, 0,  0, 1, 1, 0,  4, 4, 4);
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 5, 4);
        tbl[15] = mk(1, 1, 0, 0, 0, 1, 0,  0, 1, 1, 0,  5, 5, 4);
        tbl[16] = mk(1, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0,  0, 5, 4);
        tbl[17] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 4, 4);
        tbl[18] = mk(1, 0, 0, 0, 0, 1, 0,  1, 1, 1, 0,  6, 4, 4);
        tbl[19] = mk(1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0,  0, 4, 4);
        tbl[20] = mk(1, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 4);
        tbl[21] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 4);
        tbl[22] = mk(1, 1, 0, 0, 0, 0, 0,  0, 1, 1, 0,  7, 0, 4);
        tbl[23] = mk(1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0,  0, 1, 4);
        tbl[24] = mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 1, 4);
        tbl[25] = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0,  0, 1, 4);
        tbl[26] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 1, 4);
        tbl[27] = mk(1, 1, 0, 0, 0, 0, 0,  0, 1, 1, 0,  8, 1, 4);
        tbl[28] = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 2, 4);

        do_reset();
        for (int i = 0; i < 29; i++) step(tbl[i], $sformatf("v%0d", i));

        // ROB fill to 16, stall on full, commit frees a slot and the tag wraps to 0.
        do_reset();
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, -1), "wrap.pop");
        for (int k = 0; k < 16; k++)
            step(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, k, k, -1), $sformatf("wrap.i%0d", k));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16, 0), "wrap.full");
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16, 1), "wrap.cmt");
        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 15, 2), "wrap.iss");
        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16, 2), "wrap.end");

        // Async reset while an instruction is held and stalled.
        do_reset();
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "ar.pop");
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0), "ar.iss");
        step(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "ar.stall");
        rs_full = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar.pop", iq_pop, 1'b0);
        chk("ar.strobes", {issue_rob, issue_rs, issue_slb}, 3'b000);
        chk("ar.cnt", rob_count, 5'd0);
        chk("ar.stall", stall_cnt, 16'd0);
        chk("ar.fields", {issue_pc, issue_imm}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++)
            step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("ar.post%0d", k));

        v = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(v, "final");
        chk("sb.drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
